// File: rtl/srff_bank_if.sv
// Bundle of control inputs and state outputs for the srff_bank flip-flop array.
// The master drives the controls and the slave (srff_bank) drives the state outputs.
interface srff_bank_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic             sclr;
    logic             cnt_clr;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qd;
    logic [WIDTH-1:0] illegal;
    logic [CNT_W-1:0] err_cnt;
    logic             err_sat;

    modport master (
        output en, mode, s, r, sclr, cnt_clr,
        input  q, qd, illegal, err_cnt, err_sat
    );

    modport slave (
        input  en, mode, s, r, sclr, cnt_clr,
        output q, qd, illegal, err_cnt, err_sat
    );
endinterface

// File: rtl/srff_bank.sv
// Array of WIDTH flip-flops sharing one mode select (SR/JK/D/T), with per-channel
// SR-illegal flags and a saturating count of cycles in which any SR 11 was seen.
module srff_bank #(
    parameter int               WIDTH   = 8,
    parameter int               CNT_W   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic        clk,
    input  logic        reset,
    srff_bank_if.slave  bus
);
    localparam logic [1:0]       MODE_SR  = 2'b00;
    localparam logic [1:0]       MODE_JK  = 2'b01;
    localparam logic [1:0]       MODE_D   = 2'b10;
    localparam logic [1:0]       MODE_T   = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_ill;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;
    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] w_ill_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_hit;

    // SR: set wins when only S, reset when only R, and both 00 and 11 keep the old value
    function automatic logic [WIDTH-1:0] sr_next(input logic [WIDTH-1:0] q,
                                                 input logic [WIDTH-1:0] s,
                                                 input logic [WIDTH-1:0] r);
        return (s & ~r) | (q & ~(s ^ r));
    endfunction

    function automatic logic [WIDTH-1:0] jk_next(input logic [WIDTH-1:0] q,
                                                 input logic [WIDTH-1:0] j,
                                                 input logic [WIDTH-1:0] k);
        return (j & ~q) | (~k & q);
    endfunction

    // Per-channel next state and illegal flags, with sclr above en above mode
    always_comb begin
        w_q_nxt   = r_q;
        w_ill_nxt = r_ill;
        w_hit     = 1'b0;
        if (bus.sclr) begin
            w_q_nxt   = RST_VAL;
            w_ill_nxt = {WIDTH{1'b0}};
        end else if (bus.en) begin
            w_ill_nxt = {WIDTH{1'b0}};
            case (bus.mode)
                MODE_SR: begin
                    w_q_nxt   = sr_next(r_q, bus.s, bus.r);
                    w_ill_nxt = bus.s & bus.r;
                    w_hit     = |(bus.s & bus.r);
                end
                MODE_JK: w_q_nxt = jk_next(r_q, bus.s, bus.r);
                MODE_D:  w_q_nxt = bus.s;
                MODE_T:  w_q_nxt = r_q ^ bus.s;
                default: w_q_nxt = r_q;
            endcase
        end else begin
            w_q_nxt   = r_q;
            w_ill_nxt = r_ill;
        end
    end

    // Saturating error counter; cnt_clr beats a same-cycle increment
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (bus.cnt_clr) begin
            w_cnt_nxt = CNT_ZERO;
        end else if (w_hit && (r_cnt != CNT_MAX)) begin
            w_cnt_nxt = r_cnt + CNT_ONE;
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // State registers; err_sat is registered alongside the count it describes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q   <= RST_VAL;
            r_ill <= {WIDTH{1'b0}};
            r_cnt <= CNT_ZERO;
            r_sat <= 1'b0;
        end else begin
            r_q   <= w_q_nxt;
            r_ill <= w_ill_nxt;
            r_cnt <= w_cnt_nxt;
            r_sat <= (w_cnt_nxt == CNT_MAX);
        end
    end

    assign bus.q       = r_q;
    assign bus.qd      = ~r_q;
    assign bus.illegal = r_ill;
    assign bus.err_cnt = r_cnt;
    assign bus.err_sat = r_sat;
endmodule

// File: tb/tb_srff_bank.sv
// Directed bench for srff_bank at WIDTH=4, CNT_W=2, RST_VAL=0 with hand-computed expectations.
module tb_srff_bank;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    srff_bank_if #(.WIDTH(4), .CNT_W(2)) bus();

    srff_bank #(.WIDTH(4), .CNT_W(2), .RST_VAL(4'b0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [1:0] mode, input logic [3:0] s,
                         input logic [3:0] r, input logic sclr, input logic cnt_clr);
        bus.en      = en;
        bus.mode    = mode;
        bus.s       = s;
        bus.r       = r;
        bus.sclr    = sclr;
        bus.cnt_clr = cnt_clr;
    endtask

    task automatic check_all(input string tag, input logic [3:0] q, input logic [3:0] ill,
                             input logic [1:0] cnt, input logic sat);
        check_val({tag, ".q"},   {4'b0000, bus.q},       {4'b0000, q});
        check_val({tag, ".qd"},  {4'b0000, bus.qd},      {4'b0000, ~q});
        check_val({tag, ".ill"}, {4'b0000, bus.illegal}, {4'b0000, ill});
        check_val({tag, ".cnt"}, {6'b000000, bus.err_cnt}, {6'b000000, cnt});
        check_val({tag, ".sat"}, {7'b0000000, bus.err_sat}, {7'b0000000, sat});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b0;
        drive(1'b0, 2'b00, 4'b0000, 4'b0000, 1'b0, 1'b0);
        #2;
        check_all("por", 4'b0000, 4'b0000, 2'd0, 1'b0);
        #10;
        reset = 1'b1;

        // SR with one illegal channel: bit0 holds, bit1 sets
        drive(1'b1, 2'b00, 4'b0011, 4'b0101, 1'b0, 1'b0);
        step();
        check_all("sr_mix", 4'b0010, 4'b0001, 2'd1, 1'b0);

        // clear counter with en low: q and illegal hold
        drive(1'b0, 2'b00, 4'b1111, 4'b1111, 1'b0, 1'b1);
        step();
        check_all("cclr_hold", 4'b0010, 4'b0001, 2'd0, 1'b0);

        // SR 11 on every channel for five edges: saturate at 3
        drive(1'b1, 2'b00, 4'b1111, 4'b1111, 1'b0, 1'b0);
        step(); check_all("sat1", 4'b0010, 4'b1111, 2'd1, 1'b0);
        step(); check_all("sat2", 4'b0010, 4'b1111, 2'd2, 1'b0);
        step(); check_all("sat3", 4'b0010, 4'b1111, 2'd3, 1'b1);
        step(); check_all("sat4", 4'b0010, 4'b1111, 2'd3, 1'b1);
        step(); check_all("sat5", 4'b0010, 4'b1111, 2'd3, 1'b1);
        bus.cnt_clr = 1'b1;
        step();
        check_all("cclr_win", 4'b0010, 4'b1111, 2'd0, 1'b0);

        // sclr with SR 11 active: q/illegal cleared, no count
        drive(1'b1, 2'b00, 4'b1111, 4'b1111, 1'b1, 1'b0);
        step();
        check_all("sclr_sr", 4'b0000, 4'b0000, 2'd0, 1'b0);

        // JK toggle on all channels
        drive(1'b1, 2'b01, 4'b1111, 4'b1111, 1'b0, 1'b0);
        step(); check_all("jk1", 4'b1111, 4'b0000, 2'd0, 1'b0);
        step(); check_all("jk2", 4'b0000, 4'b0000, 2'd0, 1'b0);
        step(); check_all("jk3", 4'b1111, 4'b0000, 2'd0, 1'b0);

        // one SR 11 edge to get a nonzero count, then T on bits 0 and 2
        drive(1'b1, 2'b00, 4'b1111, 4'b1111, 1'b0, 1'b0);
        step(); check_all("sr_hold", 4'b1111, 4'b1111, 2'd1, 1'b0);
        drive(1'b1, 2'b11, 4'b0101, 4'b1111, 1'b0, 1'b0);
        step(); check_all("t_tog", 4'b1010, 4'b0000, 2'd1, 1'b0);

        // asynchronous reset mid-cycle, then an edge while held low with hostile inputs
        drive(1'b1, 2'b00, 4'b1111, 4'b1111, 1'b1, 1'b1);
        reset = 1'b0;
        #1;
        check_all("areset", 4'b0000, 4'b0000, 2'd0, 1'b0);
        drive(1'b1, 2'b10, 4'b1111, 4'b0000, 1'b0, 1'b0);
        step();
        check_all("rst_held", 4'b0000, 4'b0000, 2'd0, 1'b0);
        drive(1'b1, 2'b00, 4'b0001, 4'b0001, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        step();
        check_all("rel_sr", 4'b0000, 4'b0001, 2'd1, 1'b0);

        // D mode: hold with en low, load with en high, sclr with en low
        drive(1'b0, 2'b10, 4'b1001, 4'b0000, 1'b0, 1'b0);
        step(); check_all("d_hold", 4'b0000, 4'b0001, 2'd1, 1'b0);
        bus.en = 1'b1;
        step(); check_all("d_load", 4'b1001, 4'b0000, 2'd1, 1'b0);
        drive(1'b1, 2'b00, 4'b1111, 4'b0000, 1'b0, 1'b0);
        step(); check_all("sr_set", 4'b1111, 4'b0000, 2'd1, 1'b0);
        drive(1'b1, 2'b00, 4'b0011, 4'b0011, 1'b0, 1'b0);
        step(); check_all("sr_ill2", 4'b1111, 4'b0011, 2'd2, 1'b0);
        drive(1'b0, 2'b10, 4'b1001, 4'b0000, 1'b1, 1'b0);
        step(); check_all("sclr_en0", 4'b0000, 4'b0000, 2'd2, 1'b0);

        // SR->D switch on the same edge as s=r=1111: plain D load, no illegal
        drive(1'b1, 2'b10, 4'b1111, 4'b1111, 1'b0, 1'b0);
        step(); check_all("sw_sr_d", 4'b1111, 4'b0000, 2'd2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
